dpram_stream_reader: RTL
========================

// Module: dpram_stream_reader
// PURPOSE
//  Read-side client for one port of a dual-port RAM (registered read, 1-cycle latency).
//  - On a start command, reads `length` consecutive words from `start_addr`.
//  - Emits them in order on a valid/ready byte stream; backpressure is absorbed by an internal 4-entry FIFO.
//  - Used to drain disk-sector and capture buffers to serial and host-transfer logic.
// PARAMETERS
//  DATA   8         word width; must match the RAM DATA width
//  ADDR   14        RAM address width; addresses wrap modulo 2**ADDR
//  LEN_W  ADDR+1    width of `length`; range 0..2**ADDR
// PORTS
//  clk         in   1      single clock; drives this block and the RAM port it owns
//  reset       in   1      synchronous, active-high
//  start       in   1      request a transfer; sampled only when busy=0
//  start_addr  in   ADDR   first RAM address of the transfer
//  length      in   LEN_W  number of words to read
//  busy        out  1      a transfer is in progress
//  done        out  1      one-cycle pulse; the transfer is complete
//  ram_ce      out  1      read strobe to the RAM port ce input
//  ram_wr      out  1      tied 0; this block never writes
//  ram_addr    out  ADDR   registered address to the RAM port
//  ram_dout    in   DATA   RAM port read data; valid in the cycle after ram_addr is sampled
//  m_valid     out  1      stream data valid
//  m_data      out  DATA   stream data
//  m_last      out  1      marks the final word of the transfer
//  m_ready     in   1      sink accepts the beat when m_valid&m_ready
// BEHAVIOUR
//  Reset values
//  - busy, done, ram_ce, ram_wr, m_valid and m_last are 0.
//  - ram_addr and m_data are 0; the FIFO and all counters are cleared.
//  Reset mid-transfer
//  - Aborts immediately; no further beats are emitted.
//  - RAM reads still in flight are discarded.
//  FSM: IDLE -> RUN -> IDLE
//  - IDLE: start=1 with length>0 latches start_addr and length, then moves to RUN.
//  - IDLE: start=1 with length==0 pulses done in the next cycle and stays IDLE; busy stays 0.
//  - RUN: issues reads until `length` reads have been issued, then waits for the FIFO to drain.
//  - RUN -> IDLE: on the handshake of the m_last beat. done=1 in the following cycle with busy=0.
//  - A start in the done cycle is accepted.
//  - start while busy=1 is ignored.
//  Read issue (credit based)
//  - A read issues in a cycle only if fifo_occupancy + reads_in_flight < 4.
//  - Occupancy is counted after any same-cycle pop.
//  - Each issued read asserts ram_ce for that cycle; ram_addr then increments by 1, wrapping 2**ADDR-1 -> 0.
//  - A read in flight is written into the FIFO from ram_dout exactly 1 cycle later.
//  Latency and throughput
//  - With start=1 in cycle N and m_ready=1: ram_addr=start_addr in N+1 and the first m_valid is in N+3.
//  - Throughput is 1 beat per clock while m_ready=1.
//  Stream rules
//  - While m_valid=1 and m_ready=0: m_data and m_last hold stable and m_valid stays 1.
//  - No word is dropped, duplicated or reordered.
//  - m_last is 1 only on the length-th beat.
//  Counters
//  - The issue counter and the beat counter are LEN_W wide.
//  - length=2**ADDR reads the whole RAM exactly once, starting at start_addr.
// TESTING
//  1. mem[0x0010..0x0013]=A0..A3, start_addr=0x0010, len=4, m_ready=1 -> m_data A0..A3 in N+3..N+6; m_last on A3; done in N+7.
//  2. start_addr=0x3FFE, len=4 -> ram_addr sequence 3FFE,3FFF,0000,0001; beats in that order.
//  3. len=8 with m_ready low for 10 cycles then toggling 1,0 -> ram_ce stops at 4 outstanding; m_data stable while stalled; all 8 words exact, in order.
//  4. len=0 -> done=1 in N+1 only; busy, m_valid and ram_ce never assert.
//  5. start pulsed again while busy -> ignored; reset after beat 2 of len=6 -> next cycle all outputs 0; a fresh len=2 transfer then completes correctly.
//  6. len=16384 from 0x1234, m_ready random 50% -> 16384 beats matching mem[(0x1234+i)%16384]; a single m_last; one done.

Source files
------------

// File: rtl/dpram_stream_reader.sv
// Streams `length` consecutive words from one port of a registered-read dual-port RAM
// onto a valid/ready byte stream, with a 4-entry FIFO and credit-based read issue.
module dpram_stream_reader #(
  parameter int DATA  = 8,
  parameter int ADDR  = 14,
  parameter int LEN_W = ADDR + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [ADDR-1:0]  start_addr_i,
  input  logic [LEN_W-1:0] length_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             ram_ce_o,
  output logic             ram_wr_o,
  output logic [ADDR-1:0]  ram_addr_o,
  input  logic [DATA-1:0]  ram_dout_i,
  output logic             m_valid_o,
  output logic [DATA-1:0]  m_data_o,
  output logic             m_last_o,
  input  logic             m_ready_i
);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [ADDR-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LEN_W-1:0] beats_q, beats_d;
  logic             done_q, done_d;
  logic             inflight_q;

  logic [DATA-1:0]  fifo_q [4];
  logic [1:0]       wr_ptr_q, rd_ptr_q;
  logic [2:0]       count_q, count_d;

  logic             push, pop, issue, last_beat;
  logic [2:0]       occ_after_pop, credits_used;

  // A read in flight lands in the FIFO from ram_dout exactly one cycle after issue.
  assign push = inflight_q;
  assign pop  = m_valid_o & m_ready_i;

  // Credits: the FIFO slot for every in-flight read is reserved before it is issued,
  // so a push can never find the FIFO full.
  assign occ_after_pop = count_q - {2'b00, pop};
  assign credits_used  = occ_after_pop + {2'b00, inflight_q};
  assign issue         = (state_q == ST_RUN) && (issued_q != len_q) && (credits_used < 3'd4);

  assign last_beat = (beats_q == len_q - LEN_W'(1));
  assign count_d   = count_q + {2'b00, push} - {2'b00, pop};

  assign busy_o     = (state_q == ST_RUN);
  assign done_o     = done_q;
  assign ram_ce_o   = issue;
  assign ram_wr_o   = 1'b0;
  assign ram_addr_o = addr_q;
  assign m_valid_o  = (count_q != 3'd0);
  assign m_data_o   = fifo_q[rd_ptr_q];
  assign m_last_o   = m_valid_o && last_beat;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    issued_d = issued_q;
    beats_d  = beats_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (length_i != '0) begin
            addr_d   = start_addr_i;
            len_d    = length_i;
            issued_d = '0;
            beats_d  = '0;
            state_d  = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (issue) begin
          addr_d   = addr_q + ADDR'(1);
          issued_d = issued_q + LEN_W'(1);
        end
        if (pop) begin
          beats_d = beats_q + LEN_W'(1);
          if (last_beat) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      beats_q    <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      beats_q    <= beats_d;
      done_q     <= done_d;
      inflight_q <= issue;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the FIFO storage is cleared too because m_data is visible straight from it
      // and must read 0 out of reset; at four entries this costs nothing.
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= ram_dout_i;
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_d;
    end
  end

endmodule
